hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline stall/flush controller for the 5-stage core.
- Covers the cases the forwarding unit cannot: load-use, taken-branch squash, I-/D-memory busy freeze, halt.
- Sits beside ID; drives the PC enable and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline-register controls.
- Sequential state: FSM plus branch-penalty counter plus a stall counter.

Parameters:
- REG_ADDR_W, 4, register specifier width
- BRANCH_PENALTY, 1, IF/ID squash cycles per taken branch (1..7)
- STALL_CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_srcReg1  in  REG_ADDR_W  ID-stage source 1
- id_srcReg2  in  REG_ADDR_W  ID-stage source 2
- id_uses_src1  in  1  ID instruction reads src1
- id_uses_src2  in  1  ID instruction reads src2
- id_is_store  in  1  ID instruction is a store (src2 = store data)
- id_branch_taken  in  1  branch resolved taken in ID
- id_ex_dstReg  in  REG_ADDR_W  EX-stage destination
- id_ex_memRead  in  1  EX-stage instruction is a load
- id_ex_regWrite  in  1  EX-stage writes a register
- imem_busy  in  1  instruction memory not ready this cycle
- dmem_busy  in  1  data memory not ready this cycle
- halt_retire  in  1  HLT instruction in WB
- pc_write_en  out  1  PC update enable
- if_id_write_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_bubble  out  1  ID/EX loads NOP
- ex_mem_hold  out  1  EX/MEM and ID/EX hold
- mem_wb_bubble  out  1  MEM/WB loads NOP
- halted  out  1  core halted (sticky)
- stall_cycles  out  STALL_CNT_W  saturating stall count

Behaviour:
- FSM states RUN, DMEM_WAIT, HALTED. Reset → RUN, branch counter 0, stall_cycles 0.
- In reset, all outputs at RUN idle values: pc_write_en=1, if_id_write_en=1, all other controls 0, halted=0.
- load_use = id_ex_memRead & id_ex_regWrite & id_ex_dstReg!=0 & ((id_uses_src1 & id_srcReg1==id_ex_dstReg) | (id_uses_src2 & ~id_is_store & id_srcReg2==id_ex_dstReg)).
  - Store-data dependence is excluded: mem-to-mem forwarding covers it.
- RUN priority: dmem_busy > load_use > branch squash > imem_busy.
  - dmem_busy: pc_write_en=0, if_id_write_en=0, ex_mem_hold=1, mem_wb_bubble=1. Next state DMEM_WAIT.
  - load_use: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 for exactly one cycle. Clears because the load advances to MEM. id_branch_taken is ignored that cycle; the branch re-evaluates next cycle.
  - id_branch_taken or branch counter!=0: if_id_flush=1, PC writes normally. On id_branch_taken with counter==0, load counter with BRANCH_PENALTY-1. Otherwise decrement while nonzero.
  - imem_busy: pc_write_en=0, if_id_flush=1. Rest of pipeline advances.
- DMEM_WAIT: same outputs as the RUN dmem_busy case while dmem_busy=1. Branch counter frozen; load_use and branch inputs ignored. The first cycle with dmem_busy=0 is a normal RUN-evaluated cycle and the state returns to RUN at that edge.
- halt_retire has priority over everything except reset. At the next edge → HALTED. In HALTED: pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1, halted=1. Only reset exits.
- stall_cycles increments each cycle pc_write_en=0 and state!=HALTED. Saturates at all-ones.
- Mid-operation reset is asynchronous: outputs return to idle values immediately and the branch counter clears.

Optional Feature:
- Macro HAZ_STALL_CNT_EN.
- Defined: stall_cycles counter built as above.
- Undefined: no counter flops; stall_cycles tied to 0. All other behaviour identical.

Decomposition:
- Shared package: FSM state enum, REG_ZERO constant, NOP encoding used by the flush/bubble consumers.
- One natural sub-module, hazard_load_use_cmp: the combinational load_use compare. Reusable by verification checkers.
- FSM, branch counter and stall counter live in the top.

Test Plan:
- LDR R3 in EX, ADD R4,R3,R5 in ID → one cycle pc_write_en=0, id_ex_bubble=1; next cycle all idle; stall_cycles=1.
- LDR R3 in EX, store with src2=R3 in ID → no stall. Same with load dst R0 and consumer src R0 → no stall.
- BRANCH_PENALTY=3, id_branch_taken pulse → if_id_flush=1 for 3 consecutive cycles, pc_write_en=1 throughout.
- dmem_busy high 4 cycles during a branch squash with counter=1 → ex_mem_hold=1, mem_wb_bubble=1 for 4 cycles, counter frozen; remaining flush issued after; stall_cycles=4.
- Simultaneous dmem_busy, load_use, id_branch_taken and imem_busy → only the dmem response observed.
- halt_retire pulse → halted=1 from next edge and stays; stall_cycles stops counting. rst_n low mid-run → all outputs idle asynchronously, stall_cycles=0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared types and constants for the pipeline hazard controller.
//   hazState_t  : controller FSM states (RUN / DMEM_WAIT / HALTED)
//   REG_ZERO    : hard-wired zero register specifier (never a real dependence)
//   NOP_INSTR   : instruction word the flush/bubble consumers load into a
//                 pipeline register when told to insert a NOP
//   hazCtrl_t   : bundle of pipeline-register control strobes
//   CTRL_*      : canonical control bundles for each stall/flush response
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    HALTED    = 2'd2
  } hazState_t;

  localparam int unsigned REG_ZERO  = 0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pcWriteEn;
    logic ifIdWriteEn;
    logic ifIdFlush;
    logic idExBubble;
    logic exMemHold;
    logic memWbBubble;
  } hazCtrl_t;

  // Free-running pipeline: PC and IF/ID load, nothing squashed or held.
  localparam hazCtrl_t CTRL_IDLE = '{pcWriteEn: 1'b1, ifIdWriteEn: 1'b1, default: 1'b0};
  // Data memory stalled: freeze front end, hold EX/MEM + ID/EX, drain MEM/WB.
  localparam hazCtrl_t CTRL_DMEM = '{exMemHold: 1'b1, memWbBubble: 1'b1, default: 1'b0};
  // Load-use: keep IF/ID and PC, inject one bubble into ID/EX.
  localparam hazCtrl_t CTRL_LOAD_USE = '{idExBubble: 1'b1, default: 1'b0};
  // Taken-branch squash: PC advances to target, IF/ID gets a NOP.
  localparam hazCtrl_t CTRL_BRANCH = '{pcWriteEn: 1'b1, ifIdWriteEn: 1'b1, ifIdFlush: 1'b1, default: 1'b0};
  // Instruction memory stalled: hold PC, feed NOP into IF/ID, rest advances.
  localparam hazCtrl_t CTRL_IMEM = '{ifIdWriteEn: 1'b1, ifIdFlush: 1'b1, default: 1'b0};
  // Halted core: front end frozen, everything downstream drained to NOPs.
  localparam hazCtrl_t CTRL_HALT = '{ifIdFlush: 1'b1, idExBubble: 1'b1, memWbBubble: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_unit_load_use_cmp.sv
// -----------------------------------------------------------------------------
// hazard_load_use_cmp
// Purely combinational load-use dependence detector between the instruction
// in ID and a load sitting in EX.
//   srcReg1/srcReg2   : ID-stage source specifiers
//   usesSrc1/usesSrc2 : ID instruction actually reads that source
//   isStore           : ID instruction is a store (src2 is store data)
//   exDstReg          : EX-stage destination specifier
//   exMemRead         : EX-stage instruction is a load
//   exRegWrite        : EX-stage instruction writes a register
//   loadUse           : one-cycle stall required
// Store data is excluded because the value is forwarded MEM-to-MEM in time.
// -----------------------------------------------------------------------------
module hazard_load_use_cmp
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] srcReg1,
  input  logic [REG_ADDR_W-1:0] srcReg2,
  input  logic                  usesSrc1,
  input  logic                  usesSrc2,
  input  logic                  isStore,
  input  logic [REG_ADDR_W-1:0] exDstReg,
  input  logic                  exMemRead,
  input  logic                  exRegWrite,
  output logic                  loadUse
);

  logic producerValid;
  logic src1Hit;
  logic src2Hit;

  assign producerValid = exMemRead & exRegWrite & (exDstReg != REG_ADDR_W'(REG_ZERO));
  assign src1Hit       = usesSrc1 & (srcReg1 == exDstReg);
  assign src2Hit       = usesSrc2 & ~isStore & (srcReg2 == exDstReg);
  assign loadUse       = producerValid & (src1Hit | src2Hit);

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Stall/flush controller for the 5-stage pipeline, placed beside ID. Handles
// what forwarding cannot: load-use, taken-branch squash, I/D-memory busy
// freeze and halt.
// Inputs : id_* (ID instruction operands/branch), id_ex_* (EX producer),
//          imem_busy, dmem_busy, halt_retire, clk, rst_n (async, active low)
// Outputs: pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
//          ex_mem_hold, mem_wb_bubble, halted (sticky), stall_cycles
// Build option: define HAZ_STALL_CNT_EN to build the saturating stall
// counter; otherwise stall_cycles is constant zero and no flops exist.
// Response priority while running: dmem_busy > load-use > branch squash >
// imem_busy. halt_retire overrides next-state; only reset leaves HALTED.
// -----------------------------------------------------------------------------
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W     = 4,
  parameter int BRANCH_PENALTY = 1,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_ADDR_W-1:0]  id_srcReg1,
  input  logic [REG_ADDR_W-1:0]  id_srcReg2,
  input  logic                   id_uses_src1,
  input  logic                   id_uses_src2,
  input  logic                   id_is_store,
  input  logic                   id_branch_taken,
  input  logic [REG_ADDR_W-1:0]  id_ex_dstReg,
  input  logic                   id_ex_memRead,
  input  logic                   id_ex_regWrite,
  input  logic                   imem_busy,
  input  logic                   dmem_busy,
  input  logic                   halt_retire,
  output logic                   pc_write_en,
  output logic                   if_id_write_en,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_hold,
  output logic                   mem_wb_bubble,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // Penalty is at most 7, so the remaining-squash count fits in 3 bits.
  localparam int BR_CNT_W = 3;

  hazState_t             stateReg, stateNext;
  logic [BR_CNT_W-1:0]   branchCntReg, branchCntNext;
  hazCtrl_t              ctrl;
  logic                  loadUse;
  logic                  branchSquash;
  logic                  running;

  hazard_load_use_cmp #(
    .REG_ADDR_W (REG_ADDR_W)
  ) uLoadUseCmp (
    .srcReg1    (id_srcReg1),
    .srcReg2    (id_srcReg2),
    .usesSrc1   (id_uses_src1),
    .usesSrc2   (id_uses_src2),
    .isStore    (id_is_store),
    .exDstReg   (id_ex_dstReg),
    .exMemRead  (id_ex_memRead),
    .exRegWrite (id_ex_regWrite),
    .loadUse    (loadUse)
  );

  // RUN and DMEM_WAIT share one evaluation: while dmem_busy is high the
  // dmem response wins anyway, and the first non-busy cycle in DMEM_WAIT is
  // an ordinary RUN cycle.
  assign running      = (stateReg != HALTED);
  assign branchSquash = id_branch_taken | (branchCntReg != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= RUN;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RUN, DMEM_WAIT: stateNext = dmem_busy ? DMEM_WAIT : RUN;
      HALTED:         stateNext = HALTED;
      default:        stateNext = RUN;
    endcase
    if (halt_retire) begin
      stateNext = HALTED;
    end
  end

  // Output logic. Reset forces idle strobes even if the ID/EX inputs would
  // otherwise request a stall, so the core sees a clean pipeline on release.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!running) begin
      ctrl = CTRL_HALT;
    end else if (dmem_busy) begin
      ctrl = CTRL_DMEM;
    end else if (loadUse) begin
      ctrl = CTRL_LOAD_USE;
    end else if (branchSquash) begin
      ctrl = CTRL_BRANCH;
    end else if (imem_busy) begin
      ctrl = CTRL_IMEM;
    end
    if (!rst_n) begin
      ctrl = CTRL_IDLE;
    end
  end

  assign pc_write_en    = ctrl.pcWriteEn;
  assign if_id_write_en = ctrl.ifIdWriteEn;
  assign if_id_flush    = ctrl.ifIdFlush;
  assign id_ex_bubble   = ctrl.idExBubble;
  assign ex_mem_hold    = ctrl.exMemHold;
  assign mem_wb_bubble  = ctrl.memWbBubble;
  assign halted         = (stateReg == HALTED);

  // Branch squash counter: the taken cycle itself is the first squash, the
  // counter covers the remaining BRANCH_PENALTY-1. It only moves on cycles
  // where the squash response is actually the one issued, so a dmem freeze
  // or load-use stall leaves the remaining squash count intact.
  always_comb begin
    branchCntNext = branchCntReg;
    if (running && !dmem_busy && !loadUse && branchSquash) begin
      if (branchCntReg == '0) begin
        branchCntNext = BR_CNT_W'(BRANCH_PENALTY - 1);
      end else begin
        branchCntNext = branchCntReg - BR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchCntReg <= '0;
    end else begin
      branchCntReg <= branchCntNext;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stallCntReg, stallCntNext;

  // Counts front-end stall cycles while running; sticks at all-ones.
  always_comb begin
    stallCntNext = stallCntReg;
    if (!ctrl.pcWriteEn && running && (stallCntReg != '1)) begin
      stallCntNext = stallCntReg + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntReg <= '0;
    end else begin
      stallCntReg <= stallCntNext;
    end
  end

  assign stall_cycles = stallCntReg;
`else
  assign stall_cycles = '0;
`endif

endmodule
